// File: rtl/sa_cache_4way.sv
// Four-way set-associative write-back, write-allocate cache with a word-wide requester
// side and a line-wide refill/eviction side; misses stall until a full line returns.
module sa_cache_4way #(
    parameter int unsigned CACHE_LINES     = 256,
    parameter int unsigned LINE_SIZE_BYTES = 64,
    parameter int unsigned TAG_BITS        = 18,
    parameter int unsigned INDEX_BITS      = 8,
    parameter int unsigned OFFSET_BITS     = 6,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDRESS_WIDTH   = 32,
    parameter int unsigned WAYS            = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [TAG_BITS-1:0]               i_tag,
    input  logic [INDEX_BITS-1:0]             i_index,
    input  logic [OFFSET_BITS-1:0]            i_offset,
    input  logic [DATA_WIDTH-1:0]             dataW,
    input  logic                              memRW,
    input  logic [8*LINE_SIZE_BYTES-1:0]      i_memory_line,
    input  logic                              i_memory_response,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [8*LINE_SIZE_BYTES-1:0]      line_data,
    output logic                              cache_miss,
    output logic [8*LINE_SIZE_BYTES-1:0]      o_evict_data,
    output logic [ADDRESS_WIDTH-1:0]          o_evict_addr,
    output logic                              o_evict
);

    localparam int unsigned LINE_SIZE_BITS = 8 * LINE_SIZE_BYTES;
    localparam int unsigned WORD_LSB       = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WORD_SEL_BITS  = OFFSET_BITS - WORD_LSB;
    localparam int unsigned WAY_BITS       = $clog2(WAYS);

    typedef enum logic {IDLE, MISS} state_t;

    state_t state_q, state_d;

    logic [LINE_SIZE_BITS-1:0] data_mem  [WAYS][CACHE_LINES];
    logic [TAG_BITS-1:0]       tag_mem   [WAYS][CACHE_LINES];
    logic [WAYS-1:0]           valid_mem [CACHE_LINES];
    logic [WAYS-1:0]           dirty_mem [CACHE_LINES];
    logic [WAYS-1:0]           ref_mem   [CACHE_LINES];

    logic [WAYS-1:0]           valid_set, dirty_set, ref_set, hit;
    logic                      hit_any;
    logic [WAY_BITS-1:0]       hit_way, victim_way;
    logic                      victim_found, clear_refs;
    logic [WAYS-1:0]           victim_onehot;
    logic [LINE_SIZE_BITS-1:0] hit_line, wr_line;
    logic [WORD_SEL_BITS-1:0]  word_sel;
    logic [DATA_WIDTH-1:0]     hit_word;
    logic                      do_hit, do_fill;
    logic                      unused_ok;

    assign unused_ok = &{1'b0, i_offset[WORD_LSB-1:0]};
    assign word_sel  = i_offset[OFFSET_BITS-1:WORD_LSB];
    assign valid_set = valid_mem[i_index];
    assign dirty_set = dirty_mem[i_index];
    assign ref_set   = ref_mem[i_index];

    // Per-way tag compare gated by valid, then one-hot OR-mux of the hit line.
    always_comb begin
        hit      = '0;
        hit_way  = '0;
        hit_line = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            hit[w]   = valid_set[w] && (tag_mem[w][i_index] == i_tag);
            hit_line = hit_line | (data_mem[w][i_index] & {LINE_SIZE_BITS{hit[w]}});
            if (hit[w]) hit_way = WAY_BITS'(w);
        end
        hit_any = |hit;
    end

    assign line_data = hit_line;

    always_comb begin
        hit_word = hit_line[word_sel*DATA_WIDTH +: DATA_WIDTH];
        wr_line  = hit_line;
        wr_line[word_sel*DATA_WIDTH +: DATA_WIDTH] = dataW;
    end

    // Victim: first invalid way, else first unreferenced way, else way 0 with refs cleared.
    always_comb begin
        victim_way   = '0;
        victim_found = 1'b0;
        clear_refs   = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_set[w]) begin
                victim_way   = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!victim_found && !ref_set[w]) begin
                victim_way   = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) clear_refs = 1'b1;
        victim_onehot = WAYS'(1) << victim_way;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        do_hit  = 1'b0;
        do_fill = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_any) do_hit  = 1'b1;
                else         state_d = MISS;
            end
            MISS: begin
                if (i_memory_response) begin
                    do_fill = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cache_miss = (state_q == MISS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < CACHE_LINES; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                ref_mem[s]   <= '0;
            end
        end else if (do_hit) begin
            ref_mem[i_index][hit_way] <= 1'b1;
            if (memRW) dirty_mem[i_index][hit_way] <= 1'b1;
        end else if (do_fill) begin
            valid_mem[i_index][victim_way] <= 1'b1;
            dirty_mem[i_index][victim_way] <= 1'b0;
            if (clear_refs) ref_mem[i_index] <= victim_onehot;
            else            ref_mem[i_index][victim_way] <= 1'b1;
        end
    end

    // Line and tag storage carry no reset; validity lives in valid_mem.
    always_ff @(posedge clk) begin
        if (do_hit && memRW) begin
            data_mem[hit_way][i_index] <= wr_line;
        end else if (do_fill) begin
            data_mem[victim_way][i_index] <= i_memory_line;
            tag_mem[victim_way][i_index]  <= i_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data       <= '0;
            o_evict      <= 1'b0;
            o_evict_data <= '0;
            o_evict_addr <= '0;
        end else begin
            o_evict <= 1'b0;
            if (do_hit) o_data <= memRW ? dataW : hit_word;
            if (do_fill && valid_set[victim_way] && dirty_set[victim_way]) begin
                o_evict      <= 1'b1;
                o_evict_data <= data_mem[victim_way][i_index];
                o_evict_addr <= {tag_mem[victim_way][i_index], i_index, OFFSET_BITS'(0)};
            end
        end
    end

endmodule

// File: tb/tb_sa_cache_4way.sv
// Directed bench for sa_cache_4way: expected read data is queued when a request is
// driven and compared when the cache delivers it; miss, refill and eviction checked inline.
module tb_sa_cache_4way;

    logic          clk = 1'b0;
    logic          rst;
    logic [17:0]   i_tag;
    logic [7:0]    i_index;
    logic [5:0]    i_offset;
    logic [31:0]   dataW;
    logic          memRW;
    logic [511:0]  i_memory_line;
    logic          i_memory_response;
    logic [31:0]   o_data;
    logic [511:0]  line_data;
    logic          cache_miss;
    logic [511:0]  o_evict_data;
    logic [31:0]   o_evict_addr;
    logic          o_evict;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   last_od;

    sa_cache_4way dut (
        .clk               (clk),
        .rst               (rst),
        .i_tag             (i_tag),
        .i_index           (i_index),
        .i_offset          (i_offset),
        .dataW             (dataW),
        .memRW             (memRW),
        .i_memory_line     (i_memory_line),
        .i_memory_response (i_memory_response),
        .o_data            (o_data),
        .line_data         (line_data),
        .cache_miss        (cache_miss),
        .o_evict_data      (o_evict_data),
        .o_evict_addr      (o_evict_addr),
        .o_evict           (o_evict)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mk_line(input logic [17:0] t, input logic [7:0] ix);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = {t[7:0], ix, 8'(k), 8'h5A};
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [511:0] l, input int k);
        return l[32*k +: 32];
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One requester access; on a miss the bench supplies 'fill' and checks eviction.
    task automatic access(input string nm, input logic [17:0] t, input logic [7:0] ix,
                          input logic [5:0] off, input logic rw, input logic [31:0] wd,
                          input logic exp_miss, input logic [511:0] fill,
                          input logic exp_ev, input logic [31:0] exp_ea,
                          input logic [511:0] exp_ed, input logic [31:0] exp_od);
        logic [31:0] got;
        i_tag    = t;
        i_index  = ix;
        i_offset = off;
        memRW    = rw;
        dataW    = wd;
        exp_q.push_back(exp_od);
        if (exp_miss) begin
            #1;
            chk({nm, "_line_nohit"}, line_data, '0);
            @(posedge clk); #1;
            chk({nm, "_miss_rise"}, 512'(cache_miss), 512'(1'b1));
            i_memory_line     = fill;
            i_memory_response = 1'b1;
            @(posedge clk); #1;
            chk({nm, "_miss_fall"}, 512'(cache_miss), 512'(1'b0));
            chk({nm, "_evict"}, 512'(o_evict), 512'(exp_ev));
            if (exp_ev) begin
                chk({nm, "_evict_addr"}, 512'(o_evict_addr), 512'(exp_ea));
                chk({nm, "_evict_data"}, o_evict_data, exp_ed);
            end
            chk({nm, "_line_refill"}, line_data, fill);
            i_memory_response = 1'b0;
            @(posedge clk); #1;
            chk({nm, "_evict_clr"}, 512'(o_evict), 512'(1'b0));
            if (exp_ev) chk({nm, "_evict_hold"}, 512'(o_evict_addr), 512'(exp_ea));
        end else begin
            @(posedge clk); #1;
            chk({nm, "_no_miss"}, 512'(cache_miss), 512'(1'b0));
        end
        got = exp_q.pop_front();
        chk({nm, "_o_data"}, 512'(o_data), 512'(got));
        last_od = got;
    endtask

    initial begin
        logic [511:0] l15, l7d;
        rst = 1'b1;
        i_tag = '0; i_index = '0; i_offset = '0; dataW = '0; memRW = 1'b0;
        i_memory_line = '0; i_memory_response = 1'b0;
        last_od = '0;
        #1;
        chk("rst_o_data", 512'(o_data), '0);
        chk("rst_miss", 512'(cache_miss), '0);
        chk("rst_evict", 512'(o_evict), '0);
        chk("rst_evict_data", o_evict_data, '0);
        chk("rst_evict_addr", 512'(o_evict_addr), '0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // First read misses, refill word0 = DEADBEEF.
        l15 = mk_line(18'h1, 8'h05);
        l15[31:0] = 32'hDEADBEEF;
        access("rd_miss", 18'h1, 8'h05, 6'd0, 1'b0, '0, 1'b1, l15, 1'b0, '0, '0, 32'hDEADBEEF);
        chk("rd_hit_line", line_data, l15);

        // Write hit then read back; byte offsets within a word alias.
        access("wr_hit", 18'h1, 8'h05, 6'd8, 1'b1, 32'h12345678, 1'b0, '0, 1'b0, '0, '0, 32'h12345678);
        access("rd_off8", 18'h1, 8'h05, 6'd8, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 32'h12345678);
        access("rd_off9", 18'h1, 8'h05, 6'd9, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 32'h12345678);
        access("rd_off0", 18'h1, 8'h05, 6'd0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 32'hDEADBEEF);
        access("rd_off60", 18'h1, 8'h05, 6'd60, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, word_of(l15, 15));

        // Clean set: fill all four ways, fifth tag replaces way 0 without eviction.
        for (int t = 1; t <= 4; t++)
            access("fill9", 18'(t), 8'h09, 6'd0, 1'b0, '0, 1'b1, mk_line(18'(t), 8'h09),
                   1'b0, '0, '0, word_of(mk_line(18'(t), 8'h09), 0));
        access("repl9", 18'h5, 8'h09, 6'd4, 1'b0, '0, 1'b1, mk_line(18'h5, 8'h09),
               1'b0, '0, '0, word_of(mk_line(18'h5, 8'h09), 1));
        access("keep9_t2", 18'h2, 8'h09, 6'd4, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0,
               word_of(mk_line(18'h2, 8'h09), 1));
        access("gone9_t1", 18'h1, 8'h09, 6'd0, 1'b0, '0, 1'b1, mk_line(18'h1, 8'h09),
               1'b0, '0, '0, word_of(mk_line(18'h1, 8'h09), 0));

        // Dirty set: way 0 modified, then forced out by a fifth tag.
        for (int t = 1; t <= 4; t++)
            access("fill7", 18'(t), 8'h07, 6'd0, 1'b0, '0, 1'b1, mk_line(18'(t), 8'h07),
                   1'b0, '0, '0, word_of(mk_line(18'(t), 8'h07), 0));
        access("dirty7", 18'h1, 8'h07, 6'd0, 1'b1, 32'hCAFEF00D, 1'b0, '0, 1'b0, '0, '0, 32'hCAFEF00D);
        l7d = mk_line(18'h1, 8'h07);
        l7d[31:0] = 32'hCAFEF00D;
        access("evict7", 18'h5, 8'h07, 6'd0, 1'b0, '0, 1'b1, mk_line(18'h5, 8'h07),
               1'b1, {18'h1, 8'h07, 6'h0}, l7d, word_of(mk_line(18'h5, 8'h07), 0));
        // Next victim is the lowest unreferenced way (tag 2), which is clean.
        access("repl7_t6", 18'h6, 8'h07, 6'd0, 1'b0, '0, 1'b1, mk_line(18'h6, 8'h07),
               1'b0, '0, '0, word_of(mk_line(18'h6, 8'h07), 0));
        chk("evict_addr_hold", 512'(o_evict_addr), 512'({18'h1, 8'h07, 6'h0}));
        chk("evict_data_hold", o_evict_data, l7d);
        access("keep7_t3", 18'h3, 8'h07, 6'd0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0,
               word_of(mk_line(18'h3, 8'h07), 0));
        access("gone7_t2", 18'h2, 8'h07, 6'd0, 1'b0, '0, 1'b1, mk_line(18'h2, 8'h07),
               1'b0, '0, '0, word_of(mk_line(18'h2, 8'h07), 0));

        // Stalled miss holds, then reset mid-miss drops it and invalidates everything.
        i_tag = 18'h20; i_index = 8'h03; i_offset = 6'd0; memRW = 1'b0;
        i_memory_response = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            chk("hold_miss", 512'(cache_miss), 512'(1'b1));
            chk("hold_o_data", 512'(o_data), 512'(last_od));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_miss", 512'(cache_miss), '0);
        chk("midrst_o_data", 512'(o_data), '0);
        chk("midrst_evict", 512'(o_evict), '0);
        chk("midrst_evict_addr", 512'(o_evict_addr), '0);
        chk("midrst_evict_data", o_evict_data, '0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        access("post_rst", 18'h1, 8'h05, 6'd0, 1'b0, '0, 1'b1, mk_line(18'h1, 8'h05),
               1'b0, '0, '0, word_of(mk_line(18'h1, 8'h05), 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
